// File: rtl/image_loader_pkg.sv
// Shared constants for the MNIST front end: input RAM map, pixel format
// and loader FSM state codes.
package image_loader_pkg;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 16;
   localparam int PIX_W     = 8;
   localparam int FRAC_BITS = 11;
   localparam int N_PIXELS  = 784;

   // BRAM_ADDRS: base of the network input activation RAM
   localparam logic [ADDR_W-1:0] INPUT = 10'd64;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_KICK = 2'd2;
   localparam logic [1:0] S_WAIT = 2'd3;

endpackage

// File: rtl/image_loader_if.sv
// Pixel stream into the loader: one 8-bit pixel per valid/ready beat,
// Sof marks pixel 0 of a frame.
interface image_loader_if;
   import image_loader_pkg::*;

   logic             Sof;
   logic             PixValid;
   logic [PIX_W-1:0] PixData;
   logic             PixReady;

   modport master (
      output Sof, PixValid, PixData,
      input  PixReady
   );

   modport slave (
      input  Sof, PixValid, PixData,
      output PixReady
   );

endinterface

// File: rtl/image_loader_pixel_to_fixed.sv
// Greyscale 0..255 to fixed point with FRAC_BITS fraction bits; the top
// bits are folded back in so 255 maps to just under 1.0.
module image_loader_pixel_to_fixed
   import image_loader_pkg::*;
#(
   parameter int DW = DATA_W
) (
   input  logic [PIX_W-1:0] pix,
   output logic [DW-1:0]    fix
);

   localparam int SH = FRAC_BITS - PIX_W;

   logic [DW-1:0] wide;

   assign wide = DW'(pix);
   assign fix  = (wide << SH) + (wide >> (PIX_W - SH));

endmodule

// File: rtl/image_loader.sv
// Frame loader: writes 784 converted pixels into the input RAM, kicks
// the network and holds off the next frame until its result is ready.
module image_loader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int N_PIXELS = image_loader_pkg::N_PIXELS,
   parameter logic [ADDR_W-1:0] BASE_ADDR = image_loader_pkg::INPUT
) (
   input  logic              Clk,
   input  logic              Reset,
   image_loader_if.slave     pix,
   output logic              WrEn,
   output logic [ADDR_W-1:0] WrAddr,
   output logic [DATA_W-1:0] WrData,
   output logic              Compute,
   input  logic              NnReady,
   output logic              Busy,
   output logic              FrameErr,
   input  logic              ErrClr
);
   import image_loader_pkg::*;

   localparam int CNT_W = $clog2(N_PIXELS);

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  idx;
   logic [1:0]        hold;
   logic              pix_ready;
   logic              acc;
   logic              stray;
   logic              restart;
   logic              wr_go;
   logic              last;
   logic              released;
   logic [DATA_W-1:0] fix;

   image_loader_pixel_to_fixed #(
      .DW (DATA_W)
   ) u_p2f (
      .pix (pix.PixData),
      .fix (fix)
   );

   assign pix.PixReady = pix_ready;

   assign acc      = pix.PixValid & pix_ready;
   assign stray    = acc & ~pix.Sof & (state == S_IDLE);
   assign restart  = acc & pix.Sof & (state == S_LOAD);
   assign wr_go    = acc & ~stray;
   assign idx      = pix.Sof ? '0 : cnt;
   assign last     = wr_go & (idx == CNT_W'(N_PIXELS - 1));
   // hold reaches 2 two cycles after Compute, masking a stale NnReady
   assign released = (state == S_WAIT) & (hold == 2'd2) & NnReady;

   always_comb begin
      state_nx = state;
      unique case (1'b1)
         (state == S_IDLE): if (wr_go) state_nx = S_LOAD;
         (state == S_LOAD): if (last) state_nx = S_KICK;
         (state == S_KICK): state_nx = S_WAIT;
         (state == S_WAIT): if (released) state_nx = S_IDLE;
         default:           state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         pix_ready <= 1'b0;
         cnt       <= '0;
         hold      <= '0;
         WrEn      <= 1'b0;
         WrAddr    <= BASE_ADDR;
         WrData    <= '0;
         Compute   <= 1'b0;
         Busy      <= 1'b0;
         FrameErr  <= 1'b0;
      end else begin
         state     <= state_nx;
         pix_ready <= (state_nx == S_IDLE) | (state_nx == S_LOAD);
         WrEn      <= wr_go;
         Compute   <= (state == S_KICK);
         if (wr_go) begin
            cnt    <= last ? '0 : idx + 1'b1;
            WrAddr <= BASE_ADDR + ADDR_W'(idx);
            WrData <= fix;
         end
         if (state == S_KICK)
            hold <= '0;
         else if ((state == S_WAIT) && (hold != 2'd2))
            hold <= hold + 1'b1;
         if (wr_go)
            Busy <= 1'b1;
         else if (released)
            Busy <= 1'b0;
         if (stray | restart)
            FrameErr <= 1'b1;
         else if (ErrClr)
            FrameErr <= 1'b0;
      end
   end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Upstream feeder for the MNIST inference core.
- Accepts a 784-pixel, 8-bit greyscale stream, one pixel per valid/ready beat, row-major. Sources are the UART or camera front end.
- Converts each pixel to the 16-bit fixed-point activation format (11 fractional bits, 1.0 = 1<<11) and writes it into the input RAM at INPUT+index.
- When the frame is complete, pulses Compute to the network, waits for its Ready, and only then accepts the next frame.

Parameters:
- N_PIXELS, 784, pixels per frame.
- BASE_ADDR, INPUT (from BRAM_ADDRS), input RAM base address.
- ADDR_W, 10, input RAM address width.
- DATA_W, 16, activation word width.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Sof  in  1  start-of-frame marker, qualified by PixValid
- PixValid  in  1  pixel beat valid
- PixData  in  8  pixel value, 0..255
- PixReady  out  1  loader accepts beat this cycle
- WrEn  out  1  input RAM write strobe
- WrAddr  out  ADDR_W  input RAM write address
- WrData  out  DATA_W  converted pixel
- Compute  out  1  one-cycle start pulse to the network
- NnReady  in  1  network result valid (level)
- Busy  out  1  high from first accepted pixel until NnReady is seen
- FrameErr  out  1  sticky; frame restart or stray beat detected
- ErrClr  in  1  clears FrameErr

Behaviour:
- Reset values: PixReady=0, WrEn=0, WrAddr=BASE_ADDR, WrData=0, Compute=0, Busy=0, FrameErr=0. The pixel counter is 0 and the FSM is IDLE.
- States: IDLE, LOAD, KICK, WAIT.
- Handshake: a beat is accepted when PixValid & PixReady. PixReady=1 only in IDLE and LOAD.
- IDLE:
  - Beat with Sof=1 is accepted as pixel 0; counter becomes 1; go to LOAD; Busy rises.
  - Beat with Sof=0 is accepted and dropped, with no write; FrameErr is set.
- LOAD:
  - Each accepted beat writes pixel [counter] and increments the counter.
  - Beat with Sof=1 is written as pixel 0, counter becomes 1, FrameErr is set. The partial frame is discarded, i.e. later overwritten.
  - When the beat that writes pixel N_PIXELS-1 is accepted, go to KICK.
- Write timing: registered, 1 cycle after acceptance.
  - WrEn=1.
  - WrAddr = BASE_ADDR + index.
  - WrData = {PixData,3'b000} + PixData[7:5], zero-extended to DATA_W. This gives 0→0, 128→1028, 255→2047.
  - No rounding, no saturation needed: the maximum is 2047 < 2^11.
- KICK:
  - Entered the cycle after the last accept, so the last write lands that same cycle.
  - Compute=1 for exactly one cycle, issued in the cycle after entry so the last write has committed to RAM; then go to WAIT.
  - Latency from last pixel accept to Compute is 2 cycles.
- WAIT:
  - PixReady=0.
  - A sample of NnReady=1 taken at least 2 cycles after Compute returns the FSM to IDLE and drops Busy. This prevents a stale Ready from the previous frame from ending the wait.
  - While in WAIT, Sof/PixValid are ignored and no error is raised.
- FrameErr:
  - Set has priority over ErrClr in the same cycle.
  - Reset clears it.
  - It does not affect the data path.
- Reset mid-frame: all state returns to reset values immediately. The RAM contents are left as written; no Compute is issued.
- Counter: width is clog2(N_PIXELS). It never wraps past N_PIXELS-1 because the transition to KICK occurs first.

Decomposition:
- Add N_PIXELS, PIX_W=8, FRAC_BITS=11 and the loader state enum to the shared BRAM_ADDRS/CONSTANTS package. Reuse INPUT from that package.
- One natural sub-module, pixel_to_fixed: the combinational conversion, kept separate so it can be swapped for a different scaling later.
- The FSM, counter and write register stay in image_loader.

Test Plan:
- Full frame: Sof on beat 0, PixData = index mod 256, 784 back-to-back beats.
  - Required: 784 writes at addresses INPUT..INPUT+783; WrData[5]=40, WrData[255]=2047.
  - Required: Compute pulses exactly once, 2 cycles after the last accept; Busy=1 throughout.
- Backpressure: during WAIT, hold PixValid=1 for 50 cycles, then pulse NnReady.
  - Required: PixReady=0 and no writes during WAIT; return to IDLE 1 cycle after NnReady is sampled.
- Bubbles: random PixValid gaps with 30% duty.
  - Required: same addresses and data as the full-frame case; Compute timing is relative to the last accept.
- Restart: Sof reasserted at pixel 400.
  - Required: FrameErr=1; next write goes to INPUT+0; Compute appears only after 784 further beats.
  - Then ErrClr=1 → FrameErr=0.
- Stray beat in IDLE with Sof=0.
  - Required: no WrEn, FrameErr=1, state stays IDLE.
- Reset asserted at pixel 300.
  - Required: all outputs at reset values next cycle, no Compute; a following clean frame completes normally.
- Stale ready: NnReady held high from the previous frame.
  - Required: the new frame still waits the full 2 cycles after Compute before leaving WAIT.
